// File: rtl/paint_pkg.sv
// Purpose : shared types and constants for the paint pixel pipeline (SRAM addressing, colours, clear FSM).
// Latency : n/a (types only).
// Backpressure : n/a.
package paint_pkg;

    localparam int ADDR_W       = 20;
    localparam int PIX_W        = 3;
    localparam int COORD_W      = 10;
    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    // Pixel address as laid out on the SRAM pins: {x[9:0], y[9:0]}.
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } pix_addr_t;

    // One 3-bit pixel, {B,G,R}.
    typedef struct packed {
        logic b;
        logic g;
        logic r;
    } rgb3_t;

    typedef enum logic {
        CLR_IDLE  = 1'b0,
        CLR_CLEAR = 1'b1
    } clr_state_t;

    // Write FIFO entry.
    typedef struct packed {
        pix_addr_t addr;
        rgb3_t     color;
    } wr_req_t;

endpackage

// File: rtl/sram_access_arbiter_if.sv
// Purpose : bundle of the arbiter's client-side streams (read, write, clear) and the SRAM pin group.
// Latency : n/a (wiring only).
// Backpressure : write stream is valid/ready; read and clear streams have none.
// Modports: slave = arbiter side, master = clients + SRAM side.
interface sram_access_arbiter_if;
    import paint_pkg::*;

    // display read stream
    pix_addr_t rd_addr;
    rgb3_t     rd_data;
    logic      rd_valid;
    // cursor write stream
    logic      wr_valid;
    logic      wr_ready;
    pix_addr_t wr_addr;
    rgb3_t     wr_data;
    // clear engine control
    logic      clr_start;
    rgb3_t     clr_color;
    logic      clr_busy;
    logic      clr_done;
    logic      err_oob;
    // SRAM pins
    pix_addr_t sram_addr;
    rgb3_t     sram_dq_o;
    logic      sram_dq_oe;
    rgb3_t     sram_dq_i;
    logic      sram_we_n;

    modport slave (
        input  rd_addr, wr_valid, wr_addr, wr_data, clr_start, clr_color, sram_dq_i,
        output rd_data, rd_valid, wr_ready, clr_busy, clr_done, err_oob,
               sram_addr, sram_dq_o, sram_dq_oe, sram_we_n
    );

    modport master (
        output rd_addr, wr_valid, wr_addr, wr_data, clr_start, clr_color, sram_dq_i,
        input  rd_data, rd_valid, wr_ready, clr_busy, clr_done, err_oob,
               sram_addr, sram_dq_o, sram_dq_oe, sram_we_n
    );

endinterface

// File: rtl/sram_wr_fifo.sv
// Purpose : synchronous write-request FIFO with push/pop/flush, registered occupancy count.
// Latency : head entry visible on o_dout the cycle after the push edge.
// Backpressure : o_full from the registered count; a push while full is refused even if popping.
// Ports: master_clk/rst, i_push/i_pop/i_flush, i_din -> o_dout, o_full/o_empty.
module sram_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 23
) (
    input  logic         master_clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_dout,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;
    assign o_dout    = r_mem[r_rptr];

    // Flush wins over a concurrent push/pop: the whole queue is discarded.
    always_ff @(posedge master_clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + AW'(1);
            if (w_pop_ok)  r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
        end
    end

    always_ff @(posedge master_clk) begin
        if (w_push_ok && !i_flush) r_mem[r_wptr] <= i_din;
    end

endmodule

// File: rtl/sram_access_arbiter.sv
// Purpose : time-slotted owner of the pixel SRAM: even cycles read for display, odd cycles write (clear > FIFO).
// Latency : read data 1 edge after address capture, held 2 cycles; FIFO push to SRAM write <= 3 cycles when idle.
// Backpressure : wr_ready = FIFO not full; display reads and clear are never stalled.
// Ports: master_clk, rst (async active-low), bus (sram_access_arbiter_if.slave).
// Optional: SRAM_ARB_RANGE_CHECK_EN discards off-screen writes and raises sticky err_oob.
module sram_access_arbiter
    import paint_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF
) (
    input  logic                  master_clk,
    input  logic                  rst,
    sram_access_arbiter_if.slave  bus
);

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_ACTIVE - 1);

    // 0 = read slot, 1 = write slot (state of the current cycle)
    logic               r_slot;
    clr_state_t         r_state;
    clr_state_t         w_state_nxt;
    logic [COORD_W-1:0] r_cx;
    logic [COORD_W-1:0] r_cy;
    rgb3_t              r_clr_color;
    logic               r_clr_done;

    pix_addr_t          r_sram_addr;
    rgb3_t              r_sram_dq_o;
    logic               r_sram_dq_oe;
    logic               r_sram_we_n;
    rgb3_t              r_rd_data;
    logic               r_rd_valid;

    logic               w_clr_busy;
    logic               w_clr_wr;
    logic               w_clr_last;
    logic               w_fifo_wr;
    logic               w_oob;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    wr_req_t            w_fifo_din;
    wr_req_t            w_fifo_dout;

    always_ff @(posedge master_clk or negedge rst) begin
        if (!rst) r_slot <= 1'b0;
        else      r_slot <= ~r_slot;
    end

    // ---------------- clear FSM: state register ----------------
    always_ff @(posedge master_clk or negedge rst) begin
        if (!rst) begin
            r_state     <= CLR_IDLE;
            r_cx        <= '0;
            r_cy        <= '0;
            r_clr_color <= '0;
            r_clr_done  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_done <= w_clr_wr && w_clr_last;
            if (bus.clr_start) begin
                r_cx        <= '0;
                r_cy        <= '0;
                r_clr_color <= bus.clr_color;
            end else if (w_clr_wr) begin
                if (r_cx == X_LAST) begin
                    r_cx <= '0;
                    r_cy <= r_cy + COORD_W'(1);
                end else begin
                    r_cx <= r_cx + COORD_W'(1);
                end
            end
        end
    end

    // ---------------- clear FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            CLR_IDLE:  if (bus.clr_start) w_state_nxt = CLR_CLEAR;
            CLR_CLEAR: if (bus.clr_start)             w_state_nxt = CLR_CLEAR;
                       else if (w_clr_wr && w_clr_last) w_state_nxt = CLR_IDLE;
        endcase
    end

    // ---------------- clear FSM: outputs ----------------
    // A clr_start edge is spent restarting/flushing, so no write issues on it.
    always_comb begin
        w_clr_busy = (r_state == CLR_CLEAR);
        w_clr_wr   = w_clr_busy && !r_slot && !bus.clr_start;
        w_clr_last = (r_cx == X_LAST) && (r_cy == Y_LAST);
    end

    // ---------------- write FIFO ----------------
`ifdef SRAM_ARB_RANGE_CHECK_EN
    logic r_err_oob;

    assign w_oob = (int'(bus.wr_addr.x) >= H_ACTIVE) || (int'(bus.wr_addr.y) >= V_ACTIVE);

    always_ff @(posedge master_clk or negedge rst) begin
        if (!rst)                                           r_err_oob <= 1'b0;
        else if (bus.wr_valid && !w_fifo_full && w_oob)     r_err_oob <= 1'b1;
    end

    assign bus.err_oob = r_err_oob;
`else
    assign w_oob       = 1'b0;
    assign bus.err_oob = 1'b0;
`endif

    // Off-screen requests are handshaken (wr_ready honoured) but never enqueued.
    assign w_fifo_din = '{addr: bus.wr_addr, color: bus.wr_data};
    assign w_fifo_wr  = !r_slot && !w_clr_busy && !bus.clr_start && !w_fifo_empty;

    sram_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(wr_req_t))
    ) u_fifo (
        .master_clk (master_clk),
        .rst        (rst),
        .i_push     (bus.wr_valid && !w_oob),
        .i_pop      (w_fifo_wr),
        .i_flush    (bus.clr_start),
        .i_din      (w_fifo_din),
        .o_dout     (w_fifo_dout),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty)
    );

    // ---------------- SRAM pin / read datapath ----------------
    // Edge with r_slot=1 enters the read slot; edge with r_slot=0 leaves it and
    // enters the write slot. Address only moves as we_n rises (tHA=0 is fine).
    always_ff @(posedge master_clk or negedge rst) begin
        if (!rst) begin
            r_sram_addr  <= '0;
            r_sram_dq_o  <= '0;
            r_sram_dq_oe <= 1'b0;
            r_sram_we_n  <= 1'b1;
            r_rd_data    <= '0;
            r_rd_valid   <= 1'b0;
        end else begin
            r_rd_valid <= !r_slot;
            if (r_slot) begin
                r_sram_addr  <= bus.rd_addr;
                r_sram_we_n  <= 1'b1;
                r_sram_dq_oe <= 1'b0;
            end else begin
                r_rd_data <= bus.sram_dq_i;
                if (w_clr_wr) begin
                    r_sram_addr  <= '{x: r_cx, y: r_cy};
                    r_sram_dq_o  <= r_clr_color;
                    r_sram_dq_oe <= 1'b1;
                    r_sram_we_n  <= 1'b0;
                end else if (w_fifo_wr) begin
                    r_sram_addr  <= w_fifo_dout.addr;
                    r_sram_dq_o  <= w_fifo_dout.color;
                    r_sram_dq_oe <= 1'b1;
                    r_sram_we_n  <= 1'b0;
                end
            end
        end
    end

    assign bus.sram_addr  = r_sram_addr;
    assign bus.sram_dq_o  = r_sram_dq_o;
    assign bus.sram_dq_oe = r_sram_dq_oe;
    assign bus.sram_we_n  = r_sram_we_n;
    assign bus.rd_data    = r_rd_data;
    assign bus.rd_valid   = r_rd_valid;
    assign bus.wr_ready   = !w_fifo_full;
    assign bus.clr_busy   = w_clr_busy;
    assign bus.clr_done   = r_clr_done;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Purpose : self-checking bench for sram_access_arbiter with a small 8x4 screen so a clear is 32 writes.
// Expected SRAM writes and read data go into queues; a negedge monitor pops and compares them.
module tb_sram_access_arbiter;
    import paint_pkg::*;

    localparam int DEPTH = 4;
    localparam int HA    = 8;
    localparam int VA    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sram_access_arbiter_if bus ();

    sram_access_arbiter #(
        .FIFO_DEPTH (DEPTH),
        .H_ACTIVE   (HA),
        .V_ACTIVE   (VA)
    ) dut (
        .master_clk (clk),
        .rst        (rst),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // SRAM model: asynchronous read, write sampled mid-pulse by the monitor.
    logic [2:0] mem [0:1048575];
    assign bus.sram_dq_i = mem[bus.sram_addr];

    // Reference slot phase: 0 after reset, toggles every edge.
    logic tb_slot;
    always @(posedge clk or negedge rst) begin
        if (!rst) tb_slot <= 1'b0;
        else      tb_slot <= ~tb_slot;
    end

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    logic [22:0] exp_wr [$];
    logic [2:0]  exp_rd [$];
    bit          prev_we_low = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, got, expv);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            chk("rd_valid_phase", 32'(bus.rd_valid), 32'(tb_slot));
            if (!bus.sram_we_n) begin
                mem[bus.sram_addr] = bus.sram_dq_o;
                chk("wr_in_write_slot", 32'(tb_slot), 32'd1);
                chk("we_pulse_one_cycle", 32'(prev_we_low), 32'd0);
                chk("wr_dq_oe", 32'(bus.sram_dq_oe), 32'd1);
                if (exp_wr.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got addr=%0h data=%0h required no write",
                             bus.sram_addr, bus.sram_dq_o);
                end else begin
                    chk("wr_addr_data", 32'({bus.sram_addr, bus.sram_dq_o}), 32'(exp_wr.pop_front()));
                end
            end
            prev_we_low = !bus.sram_we_n;
            if (bus.rd_valid && exp_rd.size() > 0)
                chk("rd_data", 32'(bus.rd_data), 32'(exp_rd.pop_front()));
            if (bus.clr_done) begin
                done_cnt++;
                chk("clr_busy_at_done", 32'(bus.clr_busy), 32'd0);
            end
        end else begin
            prev_we_low = 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic align_slot(input logic v);
        @(posedge clk); #1;
        while (tb_slot != v) begin @(posedge clk); #1; end
    endtask

    task automatic push_wr(input logic [9:0] x, input logic [9:0] y, input logic [2:0] c, input bit will_write);
        bit acc = 1'b0;
        int n = 0;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = {x, y};
        bus.wr_data  = c;
        while (!acc && n < 300) begin
            @(negedge clk);
            acc = bus.wr_ready;
            @(posedge clk); #1;
            n++;
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL push_timeout: got wr_ready=0 for %0d cycles, required acceptance", n);
        end else if (will_write) begin
            exp_wr.push_back({x, y, c});
        end
    endtask

    task automatic start_clear(input logic [2:0] c);
        bus.clr_start = 1'b1;
        bus.clr_color = c;
        @(posedge clk); #1;
        bus.clr_start = 1'b0;
        chk("clr_busy_start", 32'(bus.clr_busy), 32'd1);
        for (int cy = 0; cy < VA; cy++)
            for (int cx = 0; cx < HA; cx++)
                exp_wr.push_back({10'(cx), 10'(cy), c});
    endtask

    task automatic wait_wr(input int budget);
        int n = 0;
        while (exp_wr.size() > 0 && n < budget) begin @(posedge clk); n++; end
        #1;
        total++;
        if (exp_wr.size() != 0) begin
            bad++;
            $display("FAIL wr_drain: got %0d writes outstanding, required 0", exp_wr.size());
            exp_wr.delete();
        end
    endtask

    task automatic read_check(input logic [19:0] a, input logic [2:0] d);
        int n = 0;
        bus.rd_addr = a;
        repeat (4) @(posedge clk);
        #1;
        exp_rd.push_back(d);
        while (exp_rd.size() > 0 && n < 10) begin @(posedge clk); n++; end
        #1;
        total++;
        if (exp_rd.size() != 0) begin
            bad++;
            $display("FAIL rd_timeout: got no rd_valid in %0d cycles, required a pulse", n);
            exp_rd.delete();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        mem[{10'd5, 10'd7}] = 3'b101;
        mem[{10'd3, 10'd2}] = 3'b011;
        bus.rd_addr   = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.clr_start = 1'b0;
        bus.clr_color = '0;

        // reset state
        #3 rst = 1'b0;
        #20;
        chk("rst_we_n",     32'(bus.sram_we_n),  32'd1);
        chk("rst_wr_ready", 32'(bus.wr_ready),   32'd1);
        chk("rst_clr_busy", 32'(bus.clr_busy),   32'd0);
        chk("rst_clr_done", 32'(bus.clr_done),   32'd0);
        chk("rst_err_oob",  32'(bus.err_oob),    32'd0);
        chk("rst_rd_valid", 32'(bus.rd_valid),   32'd0);
        chk("rst_dq_oe",    32'(bus.sram_dq_oe), 32'd0);
        chk("rst_addr",     32'(bus.sram_addr),  32'd0);
        chk("rst_rd_data",  32'(bus.rd_data),    32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (8) @(posedge clk);

        // reads
        read_check({10'd3, 10'd2}, 3'b011);
        align_slot(1'b1);
        bus.rd_addr = {10'd5, 10'd7};
        @(posedge clk);
        @(posedge clk); #1;
        chk("rd_latency_data",  32'(bus.rd_data),  32'b101);
        chk("rd_latency_valid", 32'(bus.rd_valid), 32'd1);
        read_check({10'd5, 10'd7}, 3'b101);

        // idle writes, back-to-back, then read one back
        push_wr(10'd1, 10'd1, 3'b110, 1'b1);
        push_wr(10'd2, 10'd1, 3'b001, 1'b1);
        push_wr(10'd3, 10'd1, 3'b111, 1'b1);
        push_wr(10'd4, 10'd1, 3'b010, 1'b1);
        push_wr(10'd5, 10'd1, 3'b100, 1'b1);
        bus.wr_valid = 1'b0;
        wait_wr(40);
        read_check({10'd1, 10'd1}, 3'b110);

        // full clear
        done_cnt = 0;
        start_clear(3'b010);
        wait_wr(200);
        repeat (4) @(posedge clk); #1;
        chk("clr_done_count", 32'(done_cnt), 32'd1);
        chk("clr_busy_after", 32'(bus.clr_busy), 32'd0);
        read_check({10'd3, 10'd2}, 3'b010);

        // clear interaction: queued writes flushed, mid-clear writes fill FIFO then drain
        done_cnt = 0;
        align_slot(1'b0);
        push_wr(10'd6, 10'd3, 3'b111, 1'b0);
        push_wr(10'd7, 10'd3, 3'b111, 1'b0);
        bus.wr_valid = 1'b0;
        start_clear(3'b100);
        repeat (6) @(posedge clk); #1;
        push_wr(10'd0, 10'd0, 3'b001, 1'b1);
        push_wr(10'd1, 10'd0, 3'b011, 1'b1);
        push_wr(10'd2, 10'd0, 3'b101, 1'b1);
        push_wr(10'd3, 10'd0, 3'b110, 1'b1);
        chk("wr_ready_full", 32'(bus.wr_ready), 32'd0);
        push_wr(10'd4, 10'd0, 3'b111, 1'b1);
        bus.wr_valid = 1'b0;
        wait_wr(300);
        repeat (10) @(posedge clk); #1;
        chk("clr2_done_count", 32'(done_cnt), 32'd1);

        // reset in the middle of a clear write pulse
        start_clear(3'b001);
        repeat (10) @(posedge clk);
        align_slot(1'b1);
        #1;
        chk("pre_rst_we_n", 32'(bus.sram_we_n), 32'd0);
        rst = 1'b0;
        exp_wr.delete();
        #1;
        chk("midrst_we_n",     32'(bus.sram_we_n), 32'd1);
        chk("midrst_clr_busy", 32'(bus.clr_busy),  32'd0);
        chk("midrst_wr_ready", 32'(bus.wr_ready),  32'd1);
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(posedge clk); #1;

        // off-screen write
`ifdef SRAM_ARB_RANGE_CHECK_EN
        push_wr(10'd700, 10'd2, 3'b011, 1'b0);
        bus.wr_valid = 1'b0;
        repeat (10) @(posedge clk); #1;
        chk("err_oob_set", 32'(bus.err_oob), 32'd1);
`else
        push_wr(10'd700, 10'd2, 3'b011, 1'b1);
        bus.wr_valid = 1'b0;
        wait_wr(20);
        chk("err_oob_tied", 32'(bus.err_oob), 32'd0);
`endif
        push_wr(10'd2, 10'd2, 3'b101, 1'b1);
        bus.wr_valid = 1'b0;
        wait_wr(20);
        repeat (10) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation time limit, required test completion");
        $fatal(1, "watchdog expired");
    end

endmodule
